store_buffer: RTL and testbench

// - Posted-write buffer between the pipeline's memory-stage data port and a slow backing data memory.
// - Consumes memwrite/aluout/writedata each cycle; queues stores in a FIFO; drains them over a req/ack write port.
// - Returns load data to the pipeline's readdata, forwarding the youngest matching buffered store over the memory's

---
 rtl/store_buffer.sv | 139 +++++++++++++
 tb/tb_store_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the pipeline memory stage and a slow
// backing data memory. Stores are queued and drained over a req/ack port.
// Loads are forwarded from the youngest matching buffered store when one exists.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mem_write_m_i,
    input  logic [ADDR_W-1:0]      alu_out_m_i,
    input  logic [DATA_W-1:0]      write_data_m_i,
    output logic [DATA_W-1:0]      read_data_m_o,
    output logic                   stall_o,
    output logic [ADDR_W-1:0]      mem_rd_addr_o,
    input  logic [DATA_W-1:0]      mem_rd_data_i,
    output logic                   mem_wr_req_o,
    output logic [ADDR_W-1:0]      mem_wr_addr_o,
    output logic [DATA_W-1:0]      mem_wr_data_o,
    input  logic                   mem_wr_ack_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  rd_idx;

    assign full    = (count_q == CNT_W'(DEPTH));
    // A same-cycle ack does not make room: fullness is judged on the registered count.
    assign push    = mem_write_m_i & ~full;
    assign pop     = (state_q == REQ) & mem_wr_ack_i;
    assign stall_o = mem_write_m_i & full;

    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign mem_rd_addr_o = alu_out_m_i;
    assign mem_wr_addr_o = addr_q[rd_ptr_q];
    assign mem_wr_data_o = data_q[rd_ptr_q];

    // Next pointer and occupancy values from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards every pending store.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; written on enqueue only, never cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_ptr_q] <= alu_out_m_i;
            data_q[wr_ptr_q] <= write_data_m_i;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM next state and write request: IDLE waits for a registered non-empty
    // count, REQ holds the head until ack and stays while entries remain.
    always_comb begin
        state_d      = state_q;
        mem_wr_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_wr_req_o = 1'b1;
                if (count_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load forwarding: scan valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        read_data_m_o = mem_rd_data_i;
        rd_idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rd_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) &&
                (addr_q[rd_idx][ADDR_W-1:2] == alu_out_m_i[ADDR_W-1:2])) begin
                read_data_m_o = data_q[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table followed by
// randomized traffic checked against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        stall;
    logic [31:0] rd_addr;
    logic [31:0] mrd;
    logic        req;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        ack;
    logic [2:0]  cnt;
    logic        empty;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mem_write_m_i  (we),
        .alu_out_m_i    (addr),
        .write_data_m_i (wd),
        .read_data_m_o  (rdata),
        .stall_o        (stall),
        .mem_rd_addr_o  (rd_addr),
        .mem_rd_data_i  (mrd),
        .mem_wr_req_o   (req),
        .mem_wr_addr_o  (waddr),
        .mem_wr_data_o  (wdata),
        .mem_wr_ack_i   (ack),
        .count_o        (cnt),
        .empty_o        (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        bit          ack;
        int          e_cnt;
        bit          e_req;
        bit          e_stall;
        logic [31:0] e_waddr;
        logic [31:0] e_wdata;
        bit          chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [31:0] m,
                                 bit k, int c, bit q, bit s, logic [31:0] wa, logic [31:0] wdt,
                                 bit cr, logic [31:0] er);
        vec_t v;
        v.rst = r; v.we = w; v.addr = a; v.wd = d; v.mrd = m; v.ack = k;
        v.e_cnt = c; v.e_req = q; v.e_stall = s; v.e_waddr = wa; v.e_wdata = wdt;
        v.chk_rd = cr; v.e_rd = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] m, input bit k);
        rst = r; we = w; addr = a; wd = d; mrd = m; ack = k;
    endtask

    // reference model state
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    bit          req_m;

    initial begin
        drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h99, 1'b0);
        #1;
        chk("reset_count", 32'(cnt), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_req", 32'(req), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);

        // single store 0x54 <- 7, ack on the third request cycle
        vecs.push_back(row(0,1,32'h54,32'h7,32'h99,0, 0,0,0, 0,0, 0,0));
        vecs.push_back(row(0,0,32'h54,32'h0,32'h99,0, 1,0,0, 0,0, 1,32'h7));
        vecs.push_back(row(0,0,32'h0 ,32'h0,32'h99,0, 1,1,0, 32'h54,32'h7, 0,0));
        vecs.push_back(row(0,0,32'h0 ,32'h0,32'h99,0, 1,1,0, 32'h54,32'h7, 0,0));
        vecs.push_back(row(0,0,32'h0 ,32'h0,32'h99,1, 1,1,0, 32'h54,32'h7, 0,0));
        vecs.push_back(row(0,0,32'h54,32'h0,32'h99,0, 0,0,0, 0,0, 1,32'h99));
        // fill to DEPTH, stall, ack frees one slot for the next cycle
        vecs.push_back(row(0,1,32'h100,32'h1,32'h99,0, 0,0,0, 0,0, 0,0));
        vecs.push_back(row(0,1,32'h104,32'h2,32'h99,0, 1,0,0, 0,0, 0,0));
        vecs.push_back(row(0,1,32'h108,32'h3,32'h99,0, 2,1,0, 32'h100,32'h1, 0,0));
        vecs.push_back(row(0,1,32'h10C,32'h4,32'h99,0, 3,1,0, 32'h100,32'h1, 0,0));
        vecs.push_back(row(0,1,32'h110,32'h5,32'h99,0, 4,1,1, 32'h100,32'h1, 0,0));
        vecs.push_back(row(0,1,32'h110,32'h5,32'h99,1, 4,1,1, 32'h100,32'h1, 0,0));
        vecs.push_back(row(0,1,32'h110,32'h5,32'h99,0, 3,1,0, 32'h104,32'h2, 0,0));
        vecs.push_back(row(0,0,32'h110,32'h0,32'h99,0, 4,1,0, 32'h104,32'h2, 1,32'h5));
        vecs.push_back(row(0,0,32'h102,32'h0,32'h77,0, 4,1,0, 32'h104,32'h2, 1,32'h77));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,1, 4,1,0, 32'h104,32'h2, 0,0));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,1, 3,1,0, 32'h108,32'h3, 0,0));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,1, 2,1,0, 32'h10C,32'h4, 0,0));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,1, 1,1,0, 32'h110,32'h5, 0,0));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,0, 0,0,0, 0,0, 0,0));
        // forwarding of the youngest match, then simultaneous pop and push
        vecs.push_back(row(0,1,32'h10,32'hA,32'h99,0, 0,0,0, 0,0, 0,0));
        vecs.push_back(row(0,1,32'h10,32'hB,32'h99,0, 1,0,0, 0,0, 0,0));
        vecs.push_back(row(0,0,32'h12,32'h0,32'h33,0, 2,1,0, 32'h10,32'hA, 1,32'hB));
        vecs.push_back(row(0,0,32'h20,32'h0,32'h55,0, 2,1,0, 32'h10,32'hA, 1,32'h55));
        vecs.push_back(row(0,1,32'h30,32'hC,32'h99,1, 2,1,0, 32'h10,32'hA, 0,0));
        vecs.push_back(row(0,0,32'h10,32'h0,32'h66,0, 2,1,0, 32'h10,32'hB, 1,32'hB));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,1, 2,1,0, 32'h10,32'hB, 0,0));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,1, 1,1,0, 32'h30,32'hC, 0,0));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,0, 0,0,0, 0,0, 0,0));
        // reset during a handshake, then acks while idle are ignored
        vecs.push_back(row(0,1,32'h40,32'h1,32'h99,0, 0,0,0, 0,0, 0,0));
        vecs.push_back(row(0,1,32'h44,32'h2,32'h99,0, 1,0,0, 0,0, 0,0));
        vecs.push_back(row(0,1,32'h48,32'h3,32'h99,0, 2,1,0, 32'h40,32'h1, 0,0));
        vecs.push_back(row(1,0,32'h0,32'h0,32'h99,1, 3,1,0, 32'h40,32'h1, 0,0));
        vecs.push_back(row(0,0,32'h44,32'h0,32'h99,0, 0,0,0, 0,0, 1,32'h99));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,1, 0,0,0, 0,0, 0,0));
        vecs.push_back(row(0,1,32'h50,32'h9,32'h99,1, 0,0,0, 0,0, 0,0));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,1, 1,0,0, 0,0, 0,0));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,0, 1,1,0, 32'h50,32'h9, 0,0));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,1, 1,1,0, 32'h50,32'h9, 0,0));
        vecs.push_back(row(0,0,32'h0,32'h0,32'h99,0, 0,0,0, 0,0, 0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].mrd, vecs[i].ack);
            #1;
            chk($sformatf("v%0d_count", i), 32'(cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_cnt == 0));
            chk($sformatf("v%0d_req", i), 32'(req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_waddr", i), waddr, vecs[i].e_waddr);
                chk($sformatf("v%0d_wdata", i), wdata, vecs[i].e_wdata);
            end
            if (vecs[i].chk_rd) begin
                chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rd);
            end
        end

        // randomized traffic against a queue model
        req_m = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] exp_rd;
            int          sz;
            bit          accept;
            bit          popped;
            @(negedge clk);
            drive((n == 0) || ($urandom_range(0, 59) == 0),
                  $urandom_range(0, 1) == 1,
                  32'h200 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3)),
                  $urandom, $urandom,
                  $urandom_range(0, 2) != 0);
            #1;
            sz = qa.size();
            exp_rd = mrd;
            foreach (qa[j]) begin
                if (qa[j][31:2] == addr[31:2]) exp_rd = qd[j];
            end
            if (n != 0) begin
                chk("rnd_count", 32'(cnt), 32'(sz));
                chk("rnd_empty", 32'(empty), 32'(sz == 0));
                chk("rnd_stall", 32'(stall), 32'(we && sz == DEPTH));
                chk("rnd_req", 32'(req), 32'(req_m));
                chk("rnd_rdaddr", rd_addr, addr);
                chk("rnd_rdata", rdata, exp_rd);
                if (req_m && sz > 0) begin
                    chk("rnd_waddr", waddr, qa[0]);
                    chk("rnd_wdata", wdata, qd[0]);
                end
            end
            if (rst) begin
                qa.delete();
                qd.delete();
                req_m = 1'b0;
            end else begin
                popped = req_m && ack;
                accept = we && (sz < DEPTH);
                if (popped) begin
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
                if (accept) begin
                    qa.push_back(addr);
                    qd.push_back(wd);
                end
                if (!req_m) req_m = (sz != 0);
                else        req_m = (qa.size() != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
